// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and
// the alignment rule used at request acceptance.
package load_store_unit_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        CAP  = 3'd2,
        WR   = 3'd3,
        RESP = 3'd4
    } lsu_state_t;

    // An access must be naturally aligned to its own size.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] lane);
        logic bad;
        case (size)
            SZ_B:    bad = 1'b0;
            SZ_H:    bad = lane[0];
            SZ_W:    bad = |lane[1:0];
            default: bad = |lane;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_lane_merge.sv
// Byte-lane datapath: extracts and extends a load from a dword, and merges
// store bytes into a dword for read-modify-write.
module lsu_lane_merge
    import load_store_unit_pkg::*;
(
    input  logic [63:0] i_dword,
    input  logic [63:0] i_sdata,
    input  logic [2:0]  i_lane,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    output logic [63:0] o_load,
    output logic [63:0] o_merged
);

    logic [5:0]  w_shamt;
    logic [63:0] w_shifted;
    logic [63:0] w_mask;
    logic [63:0] w_lane_mask;

    assign w_shamt   = {i_lane, 3'b000};
    assign w_shifted = i_dword >> w_shamt;

    // Size-dependent byte mask and sign/zero extension of the addressed bytes.
    always_comb begin
        w_mask = '1;
        o_load = w_shifted;
        case (i_size)
            SZ_B: begin
                w_mask = 64'h0000_0000_0000_00FF;
                o_load = i_unsigned ? {56'd0, w_shifted[7:0]}
                                    : {{56{w_shifted[7]}}, w_shifted[7:0]};
            end
            SZ_H: begin
                w_mask = 64'h0000_0000_0000_FFFF;
                o_load = i_unsigned ? {48'd0, w_shifted[15:0]}
                                    : {{48{w_shifted[15]}}, w_shifted[15:0]};
            end
            SZ_W: begin
                w_mask = 64'h0000_0000_FFFF_FFFF;
                o_load = i_unsigned ? {32'd0, w_shifted[31:0]}
                                    : {{32{w_shifted[31]}}, w_shifted[31:0]};
            end
            default: begin
                w_mask = '1;
                o_load = w_shifted;
            end
        endcase
    end

    assign w_lane_mask = w_mask << w_shamt;
    assign o_merged    = (i_dword & ~w_lane_mask) | ((i_sdata << w_shamt) & w_lane_mask);

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one operation at a time against a 64-bit data memory with
// one-cycle read latency. Sub-dword stores are done as read-modify-write.
module load_store_unit
    import load_store_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [63:0] resp_rdata,
    output logic        mem_wen_D,
    output logic [29:0] mem_addr_D,
    output logic [63:0] mem_wdata_D,
    input  logic [63:0] mem_rdata_D
);

    lsu_state_t  r_state;
    lsu_state_t  w_state_d;
    logic        r_we;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [2:0]  r_lane;
    logic [29:0] r_addr;
    logic [63:0] r_wdata;
    logic [63:0] r_rdata;
    logic        r_err;
    logic        w_accept;
    logic        w_misaligned;
    logic [63:0] w_load;
    logic [63:0] w_merged;

    assign w_accept     = (r_state == IDLE) && req_valid;
    assign w_misaligned = is_misaligned(req_size, req_addr[2:0]);

    lsu_lane_merge u_lane_merge (
        .i_dword    (mem_rdata_D),
        .i_sdata    (r_wdata),
        .i_lane     (r_lane),
        .i_size     (r_size),
        .i_unsigned (r_unsigned),
        .o_load     (w_load),
        .o_merged   (w_merged)
    );

    // State register and operation/datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_we       <= 1'b0;
            r_size     <= SZ_B;
            r_unsigned <= 1'b0;
            r_lane     <= 3'd0;
            r_addr     <= 30'd0;
            r_wdata    <= 64'd0;
            r_rdata    <= 64'd0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_state_d;
            if (w_accept) begin
                r_we       <= req_we;
                r_size     <= req_size;
                r_unsigned <= req_unsigned;
                r_lane     <= req_addr[2:0];
                r_rdata    <= 64'd0;
                r_err      <= w_misaligned;
                // A misaligned request never touches memory, so leave the bus alone.
                if (!w_misaligned) begin
                    r_addr  <= {req_addr[31:3], 1'b0};
                    r_wdata <= req_wdata;
                end
            end
            if (r_state == CAP) begin
                if (r_we) begin
                    r_wdata <= w_merged;
                end else begin
                    r_rdata <= w_load;
                end
            end
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            IDLE: begin
                if (req_valid) begin
                    if (w_misaligned) begin
                        w_state_d = RESP;
                    end else if (req_we && (req_size == SZ_D)) begin
                        w_state_d = WR;
                    end else begin
                        w_state_d = RD;
                    end
                end
            end
            RD:      w_state_d = CAP;
            CAP:     w_state_d = r_we ? WR : RESP;
            WR:      w_state_d = RESP;
            RESP:    w_state_d = IDLE;
            default: w_state_d = IDLE;
        endcase
    end

    assign req_ready   = (r_state == IDLE);
    assign resp_valid  = (r_state == RESP);
    assign resp_err    = r_err;
    assign resp_rdata  = r_rdata;
    assign mem_wen_D   = (r_state == WR);
    assign mem_addr_D  = r_addr;
    assign mem_wdata_D = r_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, reset and
// back-to-back sequences, then randomized ops against a byte-level memory model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [63:0] req_wdata = 64'd0;
    logic        resp_valid;
    logic        resp_err;
    logic [63:0] resp_rdata;
    logic        mem_wen_D;
    logic [29:0] mem_addr_D;
    logic [63:0] mem_wdata_D;
    logic [63:0] mem_rdata_D;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] mem [16];
    logic [63:0] ref_mem [16];
    logic        mem_load = 1'b1;

    load_store_unit dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_err     (resp_err),
        .resp_rdata   (resp_rdata),
        .mem_wen_D    (mem_wen_D),
        .mem_addr_D   (mem_addr_D),
        .mem_wdata_D  (mem_wdata_D),
        .mem_rdata_D  (mem_rdata_D)
    );

    always #5 clk = ~clk;

    // Data memory: one-cycle read latency, write on wen.
    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 16; i++) mem[i] <= ref_mem[i];
        end else if (mem_wen_D) begin
            mem[mem_addr_D[4:1]] <= mem_wdata_D;
        end
        mem_rdata_D <= mem[mem_addr_D[4:1]];
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Reference model: memory as an array of bytes, little-endian.
    function automatic logic [7:0] rbyte(input int a);
        return ref_mem[a / 8][8 * (a % 8) +: 8];
    endfunction

    function automatic logic ref_misaligned(input logic [31:0] a, input logic [1:0] sz);
        return (a % (32'd1 << sz)) != 0;
    endfunction

    function automatic logic [63:0] ref_load(input logic [31:0] a, input logic [1:0] sz,
                                             input logic uns);
        int n = 1 << sz;
        logic [63:0] v = 64'd0;
        for (int i = 0; i < n; i++) v |= 64'(rbyte(int'(a) + i)) << (8 * i);
        if (!uns && n < 8 && v[8 * n - 1]) v |= ~64'd0 << (8 * n);
        return v;
    endfunction

    task automatic ref_store(input logic [31:0] a, input logic [1:0] sz, input logic [63:0] d);
        int n = 1 << sz;
        int b;
        for (int i = 0; i < n; i++) begin
            b = int'(a) + i;
            ref_mem[b / 8][8 * (b % 8) +: 8] = d[8 * i +: 8];
        end
    endtask

    // Issue one op, follow it to its response; optionally toggle junk requests while busy.
    task automatic do_op(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [63:0] wd, input bit noise,
                         output int lat, output logic err, output logic [63:0] rd,
                         output int wen_cnt, output logic [63:0] wen_data,
                         output logic [29:0] wen_addr, output int extra);
        lat = 0; err = 1'b0; rd = 64'd0; wen_cnt = 0; wen_data = 64'd0;
        wen_addr = 30'd0; extra = 0;
        @(negedge clk);
        chk("ready_before_op", 64'(req_ready), 64'd1);
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wd;
        @(posedge clk);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (mem_wen_D) begin
                wen_cnt++;
                wen_data = mem_wdata_D;
                wen_addr = mem_addr_D;
            end
            if (resp_valid) begin
                lat = k; err = resp_err; rd = resp_rdata;
                req_valid = 1'b0;
                break;
            end
            if (noise) begin
                req_valid = 1'($urandom_range(0, 1));
                req_we = 1'($urandom_range(0, 1));
                req_size = 2'($urandom_range(0, 3));
                req_addr = $urandom;
                req_wdata = {$urandom, $urandom};
            end else begin
                req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
        @(negedge clk);
        if (resp_valid) extra = 1;
        if (mem_wen_D) wen_cnt++;
    endtask

    // Run one op and compare against the given expectations.
    task automatic run_check(input string nm, input logic we, input logic [1:0] sz,
                             input logic uns, input logic [31:0] a, input logic [63:0] wd,
                             input bit noise, input int e_lat, input logic e_err,
                             input logic [63:0] e_rd, input int e_wen,
                             input logic [63:0] e_wdata, input logic [29:0] e_waddr);
        int lat, wen_cnt, extra;
        logic err;
        logic [63:0] rd, wdata;
        logic [29:0] waddr;
        do_op(we, sz, uns, a, wd, noise, lat, err, rd, wen_cnt, wdata, waddr, extra);
        chk({nm, ".latency"}, 64'(lat), 64'(e_lat));
        chk({nm, ".err"}, 64'(err), 64'(e_err));
        chk({nm, ".rdata"}, rd, e_rd);
        chk({nm, ".wen_cycles"}, 64'(wen_cnt), 64'(e_wen));
        chk({nm, ".extra_resp"}, 64'(extra), 64'd0);
        if (e_wen > 0) begin
            chk({nm, ".wdata"}, wdata, e_wdata);
            chk({nm, ".waddr"}, 64'(waddr), 64'(e_waddr));
        end
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [63:0] wdata;
        int          lat;
        logic        err;
        logic [63:0] rdata;
        int          wen;
        logic [63:0] wen_data;
        logic [29:0] wen_addr;
    } vec_t;

    function automatic vec_t mk(input logic we, input logic [1:0] sz, input logic uns,
                                input logic [31:0] a, input logic [63:0] wd, input int lat,
                                input logic err, input logic [63:0] rd, input int wen,
                                input logic [63:0] wdat, input logic [29:0] wadr);
        vec_t v;
        v.we = we; v.sz = sz; v.uns = uns; v.addr = a; v.wdata = wd; v.lat = lat;
        v.err = err; v.rdata = rd; v.wen = wen; v.wen_data = wdat; v.wen_addr = wadr;
        return v;
    endfunction

    initial begin
        vec_t vecs[12];
        int lat, wen_cnt, extra;
        logic err;
        logic [63:0] rd, wdata;
        logic [29:0] waddr;

        for (int i = 0; i < 16; i++) ref_mem[i] = {$urandom, $urandom};
        ref_mem[2] = 64'h8877665544332211;

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst.ready", 64'(req_ready), 64'd1);
        chk("rst.resp_valid", 64'(resp_valid), 64'd0);
        chk("rst.resp_err", 64'(resp_err), 64'd0);
        chk("rst.resp_rdata", resp_rdata, 64'd0);
        chk("rst.mem_wen", 64'(mem_wen_D), 64'd0);
        chk("rst.mem_addr", 64'(mem_addr_D), 64'd0);
        chk("rst.mem_wdata", mem_wdata_D, 64'd0);
        mem_load = 1'b0;
        rst = 1'b0;

        //                we    size  uns   addr    wdata                  lat err rdata                  wen wen_data               wen_addr
        vecs[0]  = mk(1'b0, 2'd0, 1'b0, 32'h17, 64'd0,                 3, 0, 64'hFFFFFFFFFFFFFF88, 0, 64'd0,                 30'd0);
        vecs[1]  = mk(1'b1, 2'd0, 1'b0, 32'h12, 64'h00000000000000AA,  4, 0, 64'd0,                1, 64'h8877665544AA2211,  30'h4);
        vecs[2]  = mk(1'b0, 2'd3, 1'b0, 32'h10, 64'd0,                 3, 0, 64'h8877665544AA2211, 0, 64'd0,                 30'd0);
        vecs[3]  = mk(1'b1, 2'd3, 1'b0, 32'h08, 64'h0123456789ABCDEF,  2, 0, 64'd0,                1, 64'h0123456789ABCDEF,  30'h2);
        vecs[4]  = mk(1'b0, 2'd2, 1'b0, 32'h06, 64'd0,                 1, 1, 64'd0,                0, 64'd0,                 30'd0);
        vecs[5]  = mk(1'b0, 2'd1, 1'b1, 32'h16, 64'd0,                 3, 0, 64'h0000000000008877, 0, 64'd0,                 30'd0);
        vecs[6]  = mk(1'b0, 2'd1, 1'b0, 32'h16, 64'd0,                 3, 0, 64'hFFFFFFFFFFFF8877, 0, 64'd0,                 30'd0);
        vecs[7]  = mk(1'b0, 2'd2, 1'b0, 32'h14, 64'd0,                 3, 0, 64'hFFFFFFFF88776655, 0, 64'd0,                 30'd0);
        vecs[8]  = mk(1'b0, 2'd2, 1'b1, 32'h14, 64'd0,                 3, 0, 64'h0000000088776655, 0, 64'd0,                 30'd0);
        vecs[9]  = mk(1'b0, 2'd0, 1'b1, 32'h10, 64'd0,                 3, 0, 64'h0000000000000011, 0, 64'd0,                 30'd0);
        vecs[10] = mk(1'b1, 2'd3, 1'b0, 32'h0C, 64'h1111111111111111,  1, 1, 64'd0,                0, 64'd0,                 30'd0);
        vecs[11] = mk(1'b0, 2'd3, 1'b1, 32'h08, 64'd0,                 3, 0, 64'h0123456789ABCDEF, 0, 64'd0,                 30'd0);

        for (int i = 0; i < 12; i++) begin
            run_check($sformatf("vec%0d", i), vecs[i].we, vecs[i].sz, vecs[i].uns, vecs[i].addr,
                      vecs[i].wdata, bit'(i % 2), vecs[i].lat, vecs[i].err, vecs[i].rdata,
                      vecs[i].wen, vecs[i].wen_data, vecs[i].wen_addr);
            if (vecs[i].we && !vecs[i].err) ref_store(vecs[i].addr, vecs[i].sz, vecs[i].wdata);
        end

        // Back-to-back: req_valid held high across two operations.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b1;
        req_addr = 32'h10; req_wdata = 64'd0;
        @(posedge clk);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            chk($sformatf("b2b.c%0d.resp_valid", k), 64'(resp_valid), 64'(k == 3 || k == 7));
            chk($sformatf("b2b.c%0d.ready", k), 64'(req_ready), 64'(k == 4 || k >= 8));
            if (k == 3 || k == 7) chk($sformatf("b2b.c%0d.rdata", k), resp_rdata, 64'h11);
            if (k == 5) req_valid = 1'b0;
        end

        // Reset during the write phase of a halfword RMW store.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd1; req_unsigned = 1'b0;
        req_addr = 32'h22; req_wdata = 64'h000000000000BEEF;
        @(posedge clk);
        @(negedge clk); req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rstwr.wen_in_wr", 64'(mem_wen_D), 64'd1);
        #1 rst = 1'b1;
        #1;
        chk("rstwr.wen_drop", 64'(mem_wen_D), 64'd0);
        chk("rstwr.ready_async", 64'(req_ready), 64'd1);
        repeat (2) begin
            @(negedge clk);
            chk("rstwr.no_resp_in_rst", 64'(resp_valid), 64'd0);
        end
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rstwr.no_resp_after", 64'(resp_valid), 64'd0);
            chk("rstwr.ready_after", 64'(req_ready), 64'd1);
        end
        chk("rstwr.mem_untouched", mem[4], ref_mem[4]);

        // Randomized operations against the reference model.
        for (int t = 0; t < 300; t++) begin
            logic        we, uns, mis;
            logic [1:0]  sz;
            logic [31:0] a;
            logic [63:0] wd, e_rd, e_wdata;
            int          e_lat, e_wen;
            we  = 1'($urandom_range(0, 1));
            uns = 1'($urandom_range(0, 1));
            sz  = 2'($urandom_range(0, 3));
            a   = $urandom_range(0, 127);
            if ($urandom_range(0, 9) < 7) a = (a >> sz) << sz;
            wd  = {$urandom, $urandom};
            mis = ref_misaligned(a, sz);
            e_lat   = mis ? 1 : (!we ? 3 : (sz == 2'd3 ? 2 : 4));
            e_rd    = (mis || we) ? 64'd0 : ref_load(a, sz, uns);
            e_wen   = (!mis && we) ? 1 : 0;
            if (e_wen > 0) ref_store(a, sz, wd);
            e_wdata = ref_mem[a / 8];
            run_check($sformatf("rnd%0d", t), we, sz, uns, a, wd, 1'b1, e_lat, mis, e_rd,
                      e_wen, e_wdata, 30'((a >> 3) << 1));
        end

        for (int i = 0; i < 16; i++) chk($sformatf("final_mem[%0d]", i), mem[i], ref_mem[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time bound so the bench can never hang.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not reach the end");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "timeout");
    end

endmodule
